// File: rtl/jt1943_objdma_ctl_if.sv
// Object DMA bus bundle: arbiter handshake, object RAM address/data and
// object line-buffer write port. The DMA controller is the master side.
interface jt1943_objdma_ctl_if #(
    parameter int AW = 9
);
    logic          bus_req;
    logic          bus_ack;
    logic          blen;
    logic [AW-1:0] AB;
    logic [7:0]    DB;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_din;

    modport master (
        output bus_req, blen, AB, buf_we, buf_addr, buf_din,
        input  bus_ack, DB
    );

    modport slave (
        input  bus_req, blen, AB, buf_we, buf_addr, buf_din,
        output bus_ack, DB
    );
endinterface

// File: rtl/jt1943_objdma_ctl.sv
// Object DMA sequencer: arms on an OKOUT edge, waits for vertical blank,
// takes the CPU bus and copies object RAM 0..OBJMAX into the line buffer.
// Aborts (sticky overrun) on bus-grant timeout or when blank closes early.
module jt1943_objdma_ctl #(
    parameter int            AW     = 9,
    parameter logic [AW-1:0] OBJMAX = 9'h1FF,
    parameter logic [7:0]    ACK_TO = 8'd200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen6,
    input  logic                 LVBL,
    input  logic                 OKOUT,
    jt1943_objdma_ctl_if.master  bus,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_REQ,
        S_COPY,
        S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic          arm_q, arm_d;
    logic          okout_q, okout_d;
    logic          lvbl_q, lvbl_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] ab_q, ab_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [7:0]    wdin_q, wdin_d;
    logic          we_q, we_d;
    logic          ovr_q, ovr_d;

    logic ok_rise, lv_fall, lv_rise;

    // Edge detectors on the cen6-sampled copies of OKOUT and LVBL
    always_comb begin
        ok_rise = OKOUT & ~okout_q;
        lv_fall = lvbl_q & ~LVBL;
        lv_rise = ~lvbl_q & LVBL;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            arm_q   <= 1'b0;
            okout_q <= 1'b0;
            lvbl_q  <= 1'b1;
            cnt_q   <= '0;
            ab_q    <= '0;
            waddr_q <= '0;
            wdin_q  <= '0;
            we_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            okout_q <= okout_d;
            lvbl_q  <= lvbl_d;
            cnt_q   <= cnt_d;
            ab_q    <= ab_d;
            waddr_q <= waddr_d;
            wdin_q  <= wdin_d;
            we_q    <= we_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic; everything advances only on cen6, buf_we is a one-clk pulse
    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        okout_d = okout_q;
        lvbl_d  = lvbl_q;
        cnt_d   = cnt_q;
        ab_d    = ab_q;
        waddr_d = waddr_q;
        wdin_d  = wdin_q;
        we_d    = 1'b0;
        ovr_d   = ovr_q;
        if (cen6) begin
            okout_d = OKOUT;
            lvbl_d  = LVBL;
            unique case (state_q)
                S_IDLE: begin
                    if (ok_rise) arm_d = 1'b1;
                    if (arm_q) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (lv_fall) begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        ovr_d   = 1'b0;
                    end
                end
                S_REQ: begin
                    if (bus.bus_ack) begin
                        state_d = S_COPY;
                        ab_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == ACK_TO) begin
                            state_d = S_RELEASE;
                            ovr_d   = 1'b1;
                        end
                    end
                end
                S_COPY: begin
                    // blank closing wins over the write scheduled for this tick
                    if (lv_rise) begin
                        state_d = S_RELEASE;
                        ovr_d   = 1'b1;
                    end else if (bus.bus_ack) begin
                        we_d    = 1'b1;
                        waddr_d = ab_q;
                        wdin_d  = bus.DB;
                        if (ab_q == OBJMAX) state_d = S_RELEASE;
                        else                ab_d    = ab_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!bus.bus_ack) begin
                        state_d = S_IDLE;
                        arm_d   = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state so async reset drops them at once
    always_comb begin
        bus.bus_req  = (state_q == S_REQ) || (state_q == S_COPY);
        bus.blen     = (state_q == S_COPY);
        bus.AB       = ab_q;
        bus.buf_we   = we_q;
        bus.buf_addr = waddr_q;
        bus.buf_din  = wdin_q;
        busy         = (state_q != S_IDLE);
        overrun      = ovr_q;
    end

endmodule

// File: tb/tb_jt1943_objdma_ctl.sv
// Bench for the object DMA sequencer: a control-vector table from reset,
// then full/aborted/stalled copies checked against an object RAM image.
module tb_jt1943_objdma_ctl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cen6 = 1'b0;
    logic LVBL = 1'b1;
    logic OKOUT = 1'b0;
    logic busy, overrun;

    jt1943_objdma_ctl_if #(.AW(9)) bus();

    jt1943_objdma_ctl #(.AW(9), .OBJMAX(9'h1FF), .ACK_TO(8'd200)) dut (
        .clk(clk), .rst_n(rst_n), .cen6(cen6), .LVBL(LVBL), .OKOUT(OKOUT),
        .bus(bus), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] mem [512];
    int wq_a[$];
    int wq_d[$];
    logic we_s;
    int   wa_s;

    // buf_we is one clk wide, so each write is seen exactly once here
    always @(negedge clk) begin
        if (bus.buf_we === 1'b1) begin
            wq_a.push_back(int'(bus.buf_addr));
            wq_d.push_back(int'(bus.buf_din));
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cen6 tick (two clocks); object RAM answers the current AB
    task automatic tick();
        bus.DB = mem[bus.AB];
        cen6 = 1'b1;
        @(posedge clk); #1;
        we_s = bus.buf_we;
        wa_s = int'(bus.buf_addr);
        cen6 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cen6 = 1'b0; OKOUT = 1'b0; LVBL = 1'b1; bus.bus_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic start_req(input string tag);
        OKOUT = 1'b1; LVBL = 1'b1; bus.bus_ack = 1'b0; tick();
        OKOUT = 1'b0; tick();
        tick();
        LVBL = 1'b0; tick();
        chk({tag, "_req_entry"}, bus.bus_req, 1);
        chk({tag, "_ovr_clear"}, overrun, 0);
    endtask

    task automatic run_copy(input string tag, input int ack_delay, input int abort_at,
                            input int drop_p, input int hold_at);
        int n, hold, exp_n, seq_err;
        bit held;
        wq_a.delete(); wq_d.delete();
        start_req(tag);
        repeat (ack_delay) tick();
        bus.bus_ack = 1'b1; tick();
        chk({tag, "_copy_entry"}, {bus.blen, 23'd0, bus.AB}, {1'b1, 23'd0, 9'd0});
        n = 0; hold = 0; held = 0;
        while (bus.bus_req && n < 3000) begin
            if (!held && hold_at >= 0 && int'(bus.AB) == hold_at) begin
                hold = 5; held = 1;
            end
            if (hold > 0) begin
                bus.bus_ack = 1'b0; hold--;
            end else begin
                bus.bus_ack = ($urandom_range(0, 7) < drop_p) ? 1'b0 : 1'b1;
            end
            OKOUT = (bus.AB == 9'h010);
            LVBL  = (abort_at >= 0 && int'(bus.AB) == abort_at);
            tick();
            n++;
        end
        chk({tag, "_copy_bounded"}, n < 3000, 1);
        OKOUT = 1'b0; bus.bus_ack = 1'b0;
        n = 0;
        while (busy && n < 10) begin tick(); n++; end
        chk({tag, "_idle"}, busy, 0);
        exp_n = (abort_at >= 0) ? abort_at : 512;
        seq_err = 0;
        foreach (wq_a[i]) begin
            if (wq_a[i] != i || wq_d[i] != int'(mem[i])) seq_err++;
        end
        chk({tag, "_wr_count"}, wq_a.size(), exp_n);
        chk({tag, "_wr_seq"}, seq_err, 0);
        chk({tag, "_overrun"}, overrun, (abort_at >= 0) ? 1 : 0);
        chk({tag, "_ab_final"}, bus.AB, (abort_at >= 0) ? abort_at : 511);
        // a further blank must not restart a copy
        LVBL = 1'b1; tick();
        LVBL = 1'b0; tick(); tick();
        chk({tag, "_no_rearm"}, {busy, bus.bus_req}, 0);
    endtask

    typedef struct {
        bit ok; bit lv; bit ack;
        bit busy; bit req; bit blen; bit ovr; bit we; int wa; int ab;
    } vec_t;
    vec_t tbl[17];

    initial begin
        int n;
        foreach (mem[i]) mem[i] = 8'($urandom);
        bus.DB = '0; bus.bus_ack = 1'b0;

        //            ok lv ak  bsy req bln ovr we wa ab
        tbl[0]  = '{0, 1, 0,  0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0,  0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0,  1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0,  1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0,  1, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0,  1, 1, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 1,  1, 1, 1, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 1,  1, 1, 1, 0, 1, 0, 1};
        tbl[8]  = '{0, 0, 1,  1, 1, 1, 0, 1, 1, 2};
        tbl[9]  = '{0, 0, 0,  1, 1, 1, 0, 0, 0, 2};
        tbl[10] = '{0, 0, 1,  1, 1, 1, 0, 1, 2, 3};
        tbl[11] = '{1, 0, 1,  1, 1, 1, 0, 1, 3, 4};
        tbl[12] = '{0, 1, 1,  1, 0, 0, 1, 0, 0, 4};
        tbl[13] = '{0, 1, 1,  1, 0, 0, 1, 0, 0, 4};
        tbl[14] = '{0, 1, 0,  0, 0, 0, 1, 0, 0, 4};
        tbl[15] = '{0, 1, 0,  0, 0, 0, 1, 0, 0, 4};
        tbl[16] = '{0, 0, 0,  0, 0, 0, 1, 0, 0, 4};

        do_reset();
        chk("rst_outputs",
            {busy, bus.bus_req, bus.blen, bus.buf_we, overrun, bus.AB, bus.buf_addr, bus.buf_din}, 0);

        foreach (tbl[i]) begin
            OKOUT = tbl[i].ok; LVBL = tbl[i].lv; bus.bus_ack = tbl[i].ack;
            tick();
            chk($sformatf("v%0d_ctl", i), {busy, bus.bus_req, bus.blen, overrun},
                {tbl[i].busy, tbl[i].req, tbl[i].blen, tbl[i].ovr});
            chk($sformatf("v%0d_ab", i), bus.AB, tbl[i].ab);
            chk($sformatf("v%0d_we", i), we_s, tbl[i].we);
            if (tbl[i].we) chk($sformatf("v%0d_wa", i), wa_s, tbl[i].wa);
        end

        do_reset();
        chk("rst_clears_overrun", overrun, 0);

        // grant never arrives
        wq_a.delete(); wq_d.delete();
        start_req("to");
        n = 0;
        while (bus.bus_req && n < 300) begin tick(); n++; end
        chk("to_ticks", n, 200);
        chk("to_overrun", overrun, 1);
        chk("to_no_writes", wq_a.size(), 0);
        tick();
        chk("to_idle", busy, 0);

        run_copy("full", 3, -1, 0, -1);
        run_copy("hold40", 1, -1, 0, 9'h040);
        run_copy("abort80", 0, 9'h080, 1, -1);
        for (int k = 0; k < 3; k++) begin
            run_copy($sformatf("rnd%0d", k), $urandom_range(0, 20),
                     ($urandom_range(0, 1) != 0) ? -1 : int'($urandom_range(1, 511)),
                     $urandom_range(0, 2), -1);
        end

        // asynchronous reset in the middle of a copy
        start_req("ar");
        bus.bus_ack = 1'b1; tick();
        n = 0;
        while (bus.AB != 9'h100 && n < 1000) begin tick(); n++; end
        chk("ar_reached_100", bus.AB, 9'h100);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_outputs", {bus.bus_req, bus.blen, busy, 23'd0, bus.AB}, 0);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
